mdu: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers. Sits beside the ALU in the EX stage.
- Generalises the ALU's single-cycle combinational arithmetic:
  - parametrised operand width and per-operation latency;
  - internal HI/LO state;
  - a busy signal, which the hazard unit uses to stall md-class instructions in D.
- Results are read back through MFHI/MFLO on mduRes.

---
 rtl/mdu.sv | 227 ++++++++++++++++++++++
 tb/tb_mdu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mduOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mduRes
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_mul_op;
    logic               w_div_op;
    logic               w_issue;
    logic               w_commit;
    logic               w_idle_start;

    logic               w_signed;
    logic [2*WIDTH-1:0] w_ea;
    logic [2*WIDTH-1:0] w_eb;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_dvs;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic               w_div_zero;
    logic [2*WIDTH-1:0] w_res;
    logic               w_wr;

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

    assign w_idle_start = start && (r_state == S_IDLE);
    assign w_issue      = w_idle_start && (w_mul_op || w_div_op);

    // Classify the incoming op; accumulate ops share the multiply latency.
    always_comb begin
        w_mul_op = 1'b0;
        w_div_op = 1'b0;
        case (mduOp)
            OP_MULT, OP_MULTU: w_mul_op = 1'b1;
            OP_DIV, OP_DIVU:   w_div_op = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: w_mul_op = 1'b1;
`endif
            default: ;
        endcase
    end

    // Next-state logic: idle until issue, busy until the counter drains.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Signedness of the latched op drives operand extension and sign fixup.
    always_comb begin
        w_signed = 1'b0;
        case (r_op)
            OP_MULT, OP_DIV: w_signed = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: w_signed = 1'b1;
`endif
            default: ;
        endcase
    end

    // One 2W-bit multiplier; sign extension makes the truncated product exact.
    assign w_ea   = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_eb   = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod = w_ea * w_eb;

    // Signed divide via magnitudes; the overflow case wraps to the
    // required -2^(W-1) quotient with zero remainder on its own.
    assign w_neg_a    = w_signed && r_a[WIDTH-1];
    assign w_neg_b    = w_signed && r_b[WIDTH-1];
    assign w_mag_a    = w_neg_a ? (~r_a + 1'b1) : r_a;
    assign w_mag_b    = w_neg_b ? (~r_b + 1'b1) : r_b;
    assign w_div_zero = (r_b == '0);
    assign w_dvs      = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
    assign w_uq       = w_mag_a / w_dvs;
    assign w_ur       = w_mag_a % w_dvs;
    assign w_q        = (w_neg_a ^ w_neg_b) ? (~w_uq + 1'b1) : w_uq;
    assign w_r        = w_neg_a ? (~w_ur + 1'b1) : w_ur;

    // Result selection; HI/LO cannot change while busy, so the current
    // {hi,lo} equals the value seen at the issue edge for accumulates.
    always_comb begin
        w_res = {r_hi, r_lo};
        w_wr  = 1'b0;
        case (r_op)
            OP_MULT, OP_MULTU: begin
                w_res = w_prod;
                w_wr  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                w_res = {w_r, w_q};
                w_wr  = !w_div_zero;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                w_res = {r_hi, r_lo} + w_prod;
                w_wr  = 1'b1;
            end
            OP_MSUB, OP_MSUBU: begin
                w_res = {r_hi, r_lo} - w_prod;
                w_wr  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Operand latches and busy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (w_issue) begin
            r_op  <= mduOp;
            r_a   <= srcA;
            r_b   <= srcB;
            r_cnt <= w_div_op ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // HI/LO update: result commit or direct moves when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            if (w_wr) begin
                {r_hi, r_lo} <= w_res;
            end
        end else if (w_idle_start && (mduOp == OP_MTHI)) begin
            r_hi <= srcA;
        end else if (w_idle_start && (mduOp == OP_MTLO)) begin
            r_lo <= srcA;
        end
    end

    // Read-back mux for MFHI/MFLO.
    always_comb begin
        mduRes = '0;
        if (mduOp == OP_MFHI) begin
            mduRes = r_hi;
        end else if (mduOp == OP_MFLO) begin
            mduRes = r_lo;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu.
// Build with MDU_MADD_EN defined to exercise the accumulate ops.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mduOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mduRes;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    mdu #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mduOp(mduOp),
        .srcA(srcA),
        .srcB(srcB),
        .busy(busy),
        .hi(hi),
        .lo(lo),
        .mduRes(mduRes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: counts busy cycles and compares each completion to the queue head.
    initial begin : monitor
        int cyc;
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cyc++;
            end else if (cyc != 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: busy cycles %0d, none expected", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_cycles"}, 32'(cyc), 32'(e.cyc));
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                end
                cyc = 0;
            end
        end
    end

    task automatic expect_op(input string nm, input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.name = nm;
        e.hi   = h;
        e.lo   = l;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        mduOp = op;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
        mduOp = 4'd0;
        srcA  = '0;
        srcB  = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || sb.size() != 0) && n < 60);
        if (busy || sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: busy=%b pending=%0d after %0d cycles", busy, sb.size(), n);
        end
    endtask

    task automatic read_res(input string nm, input logic [3:0] op, input logic [31:0] want);
        @(negedge clk);
        mduOp = op;
        #1;
        chk(nm, mduRes, want);
        mduOp = 4'd0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        mduOp  = 4'd0;
        srcA   = '0;
        srcB   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        // Signed multiply: -3 * 5
        expect_op("mult", 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        issue(4'd1, 32'hFFFFFFFD, 32'd5);
        wait_idle();
        read_res("mflo", 4'd6, 32'hFFFFFFF1);
        read_res("mfhi", 4'd5, 32'hFFFFFFFF);
        read_res("nop_res", 4'd0, 32'h0);

        expect_op("multu", 32'h00000001, 32'hFFFFFFFE, 5);
        issue(4'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle();

        expect_op("mult_negneg", 32'h0, 32'h4, 5);
        issue(4'd1, 32'hFFFFFFFE, 32'hFFFFFFFE);
        wait_idle();

        expect_op("multu_big", 32'hFFFFFFFC, 32'h4, 5);
        issue(4'd2, 32'hFFFFFFFE, 32'hFFFFFFFE);
        wait_idle();

        // Signed divide: -7 / 2
        expect_op("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        // 7 / -2
        expect_op("div_negb", 32'h1, 32'hFFFFFFFD, 10);
        issue(4'd3, 32'd7, 32'hFFFFFFFE);
        wait_idle();

        expect_op("div_ovf", 32'h0, 32'h80000000, 10);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        // Moves then divide by zero leaves HI/LO alone
        issue(4'd7, 32'h1234, 32'h0);
        issue(4'd8, 32'h5678, 32'h0);
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h5678);
        expect_op("divu_zero", 32'h1234, 32'h5678, 10);
        issue(4'd4, 32'd7, 32'd0);
        wait_idle();

        // Starts while busy are ignored
        expect_op("divu_busy", 32'd2, 32'd14, 10);
        issue(4'd4, 32'd100, 32'd7);
        issue(4'd1, 32'd2, 32'd3);
        issue(4'd8, 32'hDEAD, 32'h0);
        wait_idle();

`ifdef MDU_MADD_EN
        issue(4'd7, 32'h0, 32'h0);
        issue(4'd8, 32'hFFFFFFFF, 32'h0);
        expect_op("maddu", 32'h1, 32'h0, 5);
        issue(4'd10, 32'd1, 32'd1);
        wait_idle();
        issue(4'd7, 32'h0, 32'h0);
        issue(4'd8, 32'h0, 32'h0);
        expect_op("msub", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(4'd11, 32'd2, 32'd3);
        wait_idle();
`else
        issue(4'd7, 32'hAAAA, 32'h0);
        issue(4'd8, 32'hBBBB, 32'h0);
        issue(4'd9, 32'd5, 32'd5);
        #1;
        chk("rsvd_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        #1;
        chk("rsvd_hi", hi, 32'hAAAA);
        chk("rsvd_lo", lo, 32'hBBBB);
`endif

        // Reset aborts an op in flight after 4 busy cycles
        expect_op("div_abort", 32'h0, 32'h0, 4);
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (15) @(negedge clk);
        #1;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);

        // Reset coincident with start wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        mduOp = 4'd1;
        srcA  = 32'd3;
        srcB  = 32'd3;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        mduOp = 4'd0;
        #1;
        chk("rst_start_busy", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        #1;
        chk("rst_start_lo", lo, 32'h0);

        wait_idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
